// File: rtl/uart_line_ctrl.sv
// UART line controller: TX load sequencing, LSR sticky flags, RX char timeout, IIR arbitration.
// lsr/iir/intr/tsr_load registered (1 cycle), dr combinational; no backpressure, strobes act when sampled.
module uart_line_ctrl #(
    parameter int TIMEOUT_CHARS = 4
) (
    input  logic       pclk,
    input  logic       presetn,
    input  logic       fifoen,
    input  logic [2:0] ier,
    input  logic       thr_wr_en,
    input  logic       tx_fifo_empty,
    input  logic       tsr_done,
    input  logic       receive_done,
    input  logic [2:0] rx_err,
    input  logic       rbr_rd_en,
    input  logic       rbrf,
    input  logic       rx_fifo_empty,
    input  logic       rx_fifo_full,
    input  logic       below_level,
    input  logic       char_tick,
    input  logic       lsr_rd_en,
    input  logic       iir_rd_en,
    output logic       tsr_load,
    output logic       dr,
    output logic [7:0] lsr,
    output logic [3:0] iir,
    output logic       intr
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} tx_state_t;

    localparam logic [2:0] TO_MAX = 3'(TIMEOUT_CHARS);

    tx_state_t  state_q, state_d;
    logic       thr_full_q, thr_full_d;
    logic       tsr_load_q, tsr_load_d;
    logic [7:0] lsr_q, lsr_d;
    logic [3:0] iir_q, iir_d;
    logic       intr_q, intr_d;
    logic [2:0] cnt_q, cnt_d;
    logic       thre_prev_q, thre_prev_d;
    logic       ier1_prev_q, ier1_prev_d;
    logic       thre_pend_q, thre_pend_d;

    logic tx_avail, thre, cti, ls_src, rda_src;
    logic oe_d, pe_d, fe_d, bi_d, pend_set, pend_clr;

    assign dr = fifoen ? ~rx_fifo_empty : rbrf;

    always_comb begin
        tx_avail = fifoen ? ~tx_fifo_empty : thr_full_q;
        thre     = fifoen ? tx_fifo_empty : ~thr_full_q;

        state_d = state_q;
        case (state_q)
            IDLE:    if (tx_avail) state_d = LOAD;
            LOAD:    state_d = SHIFT;
            SHIFT:   if (tsr_done) state_d = tx_avail ? LOAD : IDLE;
            default: state_d = IDLE;
        endcase
        tsr_load_d = (state_d == LOAD);
        thr_full_d = thr_wr_en | (thr_full_q & ~tsr_load_q);

        // Sticky error flags live in lsr_q; a new error beats a same-cycle read clear.
        oe_d = (receive_done & (fifoen ? rx_fifo_full : rbrf)) | (lsr_q[1] & ~lsr_rd_en);
        pe_d = (receive_done & rx_err[0]) | (lsr_q[2] & ~lsr_rd_en);
        fe_d = (receive_done & rx_err[1]) | (lsr_q[3] & ~lsr_rd_en);
        bi_d = (receive_done & rx_err[2]) | (lsr_q[4] & ~lsr_rd_en);
        lsr_d = {fifoen & (pe_d | fe_d | bi_d), thre & (state_d == IDLE), thre,
                 bi_d, fe_d, pe_d, oe_d, dr};

        cnt_d = cnt_q;
        if (receive_done || rbr_rd_en || rx_fifo_empty || !fifoen)
            cnt_d = 3'd0;
        else if (char_tick && cnt_q != TO_MAX)
            cnt_d = cnt_q + 3'd1;
        cti = (cnt_q == TO_MAX) & ~rx_fifo_empty;

        thre_prev_d = thre;
        ier1_prev_d = ier[1];
        pend_set    = (thre & ~thre_prev_q) | (ier[1] & ~ier1_prev_q & thre);
        pend_clr    = thr_wr_en | (iir_rd_en & (iir_q == 4'b0010));
        thre_pend_d = pend_set | (thre_pend_q & ~pend_clr);

        ls_src  = ier[2] & (|lsr_q[4:1]);
        rda_src = ier[0] & (fifoen ? ~below_level : dr);
        if (ls_src)
            iir_d = 4'b0110;
        else if (rda_src)
            iir_d = 4'b0100;
        else if (ier[0] && cti)
            iir_d = 4'b1100;
        else if (ier[1] && thre_pend_q)
            iir_d = 4'b0010;
        else
            iir_d = 4'b0001;
        intr_d = ~iir_d[0];
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_q     <= IDLE;
            thr_full_q  <= 1'b0;
            tsr_load_q  <= 1'b0;
            lsr_q       <= 8'h60;
            iir_q       <= 4'b0001;
            intr_q      <= 1'b0;
            cnt_q       <= 3'd0;
            thre_prev_q <= 1'b1;
            ier1_prev_q <= 1'b0;
            thre_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            thr_full_q  <= thr_full_d;
            tsr_load_q  <= tsr_load_d;
            lsr_q       <= lsr_d;
            iir_q       <= iir_d;
            intr_q      <= intr_d;
            cnt_q       <= cnt_d;
            thre_prev_q <= thre_prev_d;
            ier1_prev_q <= ier1_prev_d;
            thre_pend_q <= thre_pend_d;
        end
    end

    assign tsr_load = tsr_load_q;
    assign lsr      = lsr_q;
    assign iir      = iir_q;
    assign intr     = intr_q;
endmodule

// File: tb/tb_uart_line_ctrl.sv
// Scoreboard bench for uart_line_ctrl: expected outputs queued per cycle, compared on the falling edge.
`timescale 1ns/1ps
module tb_uart_line_ctrl;
    logic       pclk = 1'b0;
    logic       presetn, fifoen, thr_wr_en, tsr_done, receive_done, rbr_rd_en;
    logic       rbrf, rx_fifo_empty, rx_fifo_full, below_level, char_tick;
    logic       lsr_rd_en, iir_rd_en;
    logic [2:0] ier, rx_err;
    logic       tx_fifo_empty;
    logic       tsr_load, dr, intr;
    logic [7:0] lsr;
    logic [3:0] iir;

    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] val;
        string      tag;
    } exp_t;

    localparam int K_LSR = 0, K_IIR = 1, K_INTR = 2, K_DR = 3;

    exp_t sb[$];
    int   exp_load[$];
    int   cyc = 0, tx_cnt = 0, loads_seen = 0;
    int   vectors = 0, miscompares = 0;

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    // Transmit FIFO model: fills on THR writes, drains on each load strobe.
    always @(posedge pclk) begin
        if (!presetn)
            tx_cnt <= 0;
        else
            tx_cnt <= tx_cnt + ((fifoen && thr_wr_en) ? 1 : 0)
                             - ((fifoen && tsr_load && tx_cnt > 0) ? 1 : 0);
    end
    assign tx_fifo_empty = (tx_cnt == 0);

    uart_line_ctrl #(.TIMEOUT_CHARS(4)) dut (
        .pclk(pclk), .presetn(presetn), .fifoen(fifoen), .ier(ier),
        .thr_wr_en(thr_wr_en), .tx_fifo_empty(tx_fifo_empty), .tsr_done(tsr_done),
        .receive_done(receive_done), .rx_err(rx_err), .rbr_rd_en(rbr_rd_en),
        .rbrf(rbrf), .rx_fifo_empty(rx_fifo_empty), .rx_fifo_full(rx_fifo_full),
        .below_level(below_level), .char_tick(char_tick), .lsr_rd_en(lsr_rd_en),
        .iir_rd_en(iir_rd_en), .tsr_load(tsr_load), .dr(dr), .lsr(lsr),
        .iir(iir), .intr(intr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %0h, want %0h", tag, cyc, got, want);
        end
    endtask

    task automatic expect_out(input int kind, input int delta, input logic [7:0] val, input string tag);
        exp_t e;
        int   pos;
        e.cyc = cyc + delta; e.kind = kind; e.val = val; e.tag = tag;
        pos = sb.size();
        while (pos > 0 && sb[pos-1].cyc > e.cyc) pos--;
        sb.insert(pos, e);
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    always @(negedge pclk) begin
        while (exp_load.size() > 0 && exp_load[0] < cyc) begin
            chk("load_missing", 0, exp_load[0]);
            void'(exp_load.pop_front());
        end
        if (tsr_load === 1'b1) begin
            loads_seen++;
            if (exp_load.size() == 0)
                chk("load_extra", 1, 0);
            else
                chk("load_cyc", cyc, exp_load.pop_front());
        end
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t       e;
            logic [7:0] got;
            e = sb.pop_front();
            case (e.kind)
                K_LSR:   got = lsr;
                K_IIR:   got = {4'h0, iir};
                K_INTR:  got = {7'h0, intr};
                default: got = {7'h0, dr};
            endcase
            chk(e.tag, got, e.val);
        end
    end

    initial begin
        int c0, w, l0;
        presetn = 0; fifoen = 0; ier = 0; thr_wr_en = 0; tsr_done = 0;
        receive_done = 0; rx_err = 0; rbr_rd_en = 0; rbrf = 0; rx_fifo_empty = 1;
        rx_fifo_full = 0; below_level = 0; char_tick = 0; lsr_rd_en = 0; iir_rd_en = 0;
        tick(); tick();
        expect_out(K_LSR, 0, 8'h60, "rst_lsr");
        expect_out(K_IIR, 0, 8'h01, "rst_iir");
        expect_out(K_INTR, 0, 8'h00, "rst_intr");
        expect_out(K_DR, 0, 8'h00, "rst_dr");
        tick(); presetn = 1; tick(); tick();

        // Single-THR transmit
        c0 = cyc;
        thr_wr_en = 1;
        exp_load.push_back(c0 + 2);
        expect_out(K_LSR, 2, 8'h00, "thr_busy_lsr");
        expect_out(K_LSR, 4, 8'h20, "thre_no_temt");
        tick(); thr_wr_en = 0;
        repeat (4) tick();
        tsr_done = 1;
        expect_out(K_LSR, 0, 8'h20, "temt_still_0");
        expect_out(K_LSR, 1, 8'h60, "temt_after_done");
        tick(); tsr_done = 0;
        repeat (3) tick();

        // FIFO transmit, three queued bytes
        fifoen = 1; tick();
        l0 = loads_seen;
        w = cyc;
        thr_wr_en = 1;
        exp_load.push_back(w + 2);
        repeat (3) tick();
        thr_wr_en = 0;
        for (int i = 0; i < 3; i++) begin
            repeat (4) tick();
            tsr_done = 1;
            if (i < 2) exp_load.push_back(cyc + 1);
            else expect_out(K_LSR, 1, 8'h60, "fifo_tx_idle_lsr");
            tick(); tsr_done = 0;
        end
        repeat (3) tick();
        chk("fifo_load_count", loads_seen - l0, 3);

        // Overrun and framing error, single-RBR mode
        fifoen = 0; tick(); tick();
        receive_done = 1; tick(); receive_done = 0; rbrf = 1; tick();
        receive_done = 1;
        expect_out(K_LSR, 1, 8'h63, "oe_set");
        expect_out(K_DR, 0, 8'h01, "dr_rbrf");
        tick(); receive_done = 0; tick();
        lsr_rd_en = 1;
        expect_out(K_LSR, 1, 8'h61, "oe_cleared");
        tick(); lsr_rd_en = 0; rbrf = 0; tick();
        receive_done = 1; rx_err = 3'b010; lsr_rd_en = 1;
        expect_out(K_LSR, 1, 8'h68, "fe_set_wins");
        tick(); receive_done = 0; rx_err = 0; lsr_rd_en = 0; tick();
        lsr_rd_en = 1;
        expect_out(K_LSR, 1, 8'h60, "fe_cleared");
        tick(); lsr_rd_en = 0; tick();

        // FIFO mode: break sets RXFE, then character timeout
        fifoen = 1; rx_err = 3'b100; receive_done = 1;
        expect_out(K_LSR, 1, 8'hF0, "bi_rxfe");
        tick(); receive_done = 0; rx_err = 0; lsr_rd_en = 1;
        expect_out(K_LSR, 1, 8'h60, "bi_cleared");
        tick(); lsr_rd_en = 0;
        ier = 3'b001; below_level = 1; rx_fifo_empty = 0;
        expect_out(K_DR, 0, 8'h01, "dr_fifo");
        tick();
        for (int k = 1; k <= 5; k++) begin
            char_tick = 1;
            if (k == 3) expect_out(K_IIR, 2, 8'h01, "cti_3ticks");
            if (k == 4) begin
                expect_out(K_IIR, 1, 8'h01, "cti_not_yet");
                expect_out(K_IIR, 2, 8'h0C, "cti_iir");
                expect_out(K_INTR, 2, 8'h01, "cti_intr");
            end
            if (k == 5) expect_out(K_IIR, 2, 8'h0C, "cti_saturated");
            tick(); char_tick = 0; tick(); tick();
        end
        rbr_rd_en = 1;
        expect_out(K_IIR, 1, 8'h0C, "cti_held");
        expect_out(K_IIR, 2, 8'h01, "cti_cleared");
        expect_out(K_INTR, 2, 8'h00, "cti_intr_low");
        tick(); rbr_rd_en = 0; rx_fifo_empty = 1;
        repeat (2) tick();
        ier = 0; below_level = 0; tick();

        // Priority: line status over THRE
        fifoen = 0; tick();
        ier = 3'b111; receive_done = 1; rx_err = 3'b001;
        expect_out(K_LSR, 1, 8'h64, "pe_set");
        expect_out(K_IIR, 2, 8'h06, "ls_iir");
        expect_out(K_IIR, 3, 8'h06, "ls_iir_hold");
        expect_out(K_INTR, 3, 8'h01, "ls_intr");
        tick(); receive_done = 0; rx_err = 0;
        repeat (3) tick();
        lsr_rd_en = 1;
        expect_out(K_IIR, 2, 8'h02, "thre_iir");
        expect_out(K_IIR, 3, 8'h02, "thre_iir_hold");
        tick(); lsr_rd_en = 0;
        repeat (3) tick();
        iir_rd_en = 1;
        expect_out(K_IIR, 2, 8'h01, "thre_ack_iir");
        expect_out(K_INTR, 2, 8'h00, "thre_ack_intr");
        tick(); iir_rd_en = 0;
        repeat (3) tick();
        ier = 0; tick();

        // Reset during SHIFT; a later tsr_done must not load
        thr_wr_en = 1;
        exp_load.push_back(cyc + 2);
        tick(); thr_wr_en = 0;
        repeat (4) tick();
        presetn = 0;
        expect_out(K_LSR, 1, 8'h60, "midrst_lsr");
        expect_out(K_IIR, 1, 8'h01, "midrst_iir");
        expect_out(K_INTR, 1, 8'h00, "midrst_intr");
        tick(); presetn = 1; tick();
        tsr_done = 1; tick(); tsr_done = 0;
        repeat (6) tick();

        chk("load_queue_left", exp_load.size(), 0);
        chk("sb_left", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/uart_line_ctrl.md
# uart_line_ctrl

Sequencing and status controller for the UART buffer datapath. It sits between the THR/RBR buffer block and the TX/RX shift registers. It issues `tsr_load` to move the next character into the transmit shifter, maintains the line status register (LSR) sticky error flags and the receiver character-timeout counter, and arbitrates the four interrupt sources into a prioritised IIR code plus a single `intr` line toward the APB slave.

## Interface
- `TIMEOUT_CHARS`, 4: character times of RX-FIFO inactivity before a character-timeout is raised (1..7).

Ports:
- `pclk`  in  1  clock; everything is on the rising edge.
- `presetn`  in  1  reset; synchronous, active-low.
- `fifoen`  in  1  1 = FIFO mode, 0 = single THR/RBR mode.
- `ier`  in  3  interrupt enables: [0] RX data/timeout, [1] THRE, [2] line status.
- `thr_wr_en`  in  1  APB write to THR.
- `tx_fifo_empty`  in  1  from the buffer block.
- `tsr_done`  in  1  one-cycle pulse when the TX shifter finishes its stop bit.
- `receive_done`  in  1  one-cycle pulse when a character is assembled.
- `rx_err`  in  3  {break, frame, parity} of the character qualified by `receive_done`.
- `rbr_rd_en`  in  1  APB read of RBR.
- `rbrf`, `rx_fifo_empty`, `rx_fifo_full`, `below_level`  in  1 each  buffer-block status.
- `char_tick`  in  1  one-cycle pulse, once per character time (baud generator).
- `lsr_rd_en`, `iir_rd_en`  in  1 each  APB read strobes.
- `tsr_load`  out  1  one-cycle load/pop strobe to the buffers and TX shifter.
- `dr`  out  1  data ready.
- `lsr`  out  8  {RXFE, TEMT, THRE, BI, FE, PE, OE, DR}.
- `iir`  out  4  interrupt identification.
- `intr`  out  1  interrupt request, equal to ~`iir[0]`.

## Operation
- `tx_avail` = `fifoen` ? ~`tx_fifo_empty` : `thr_full`.
  - `thr_full` is set by `thr_wr_en` and cleared by `tsr_load`. Set wins over clear.
  - Writing while `thr_full` is set overwrites the THR; no error is flagged.
- TX FSM states:
  - IDLE: if `tx_avail`, go to LOAD.
  - LOAD: `tsr_load` = 1 for exactly this one cycle, then go to SHIFT.
  - SHIFT: on `tsr_done`, go to LOAD if `tx_avail`, else go to IDLE.
- THRE = `fifoen` ? `tx_fifo_empty` : ~`thr_full`. TEMT = THRE & (state == IDLE).
- `dr` = `fifoen` ? ~`rx_fifo_empty` : `rbrf`.
- OE (sticky) is set on `receive_done` & (`fifoen` ? `rx_fifo_full` : `rbrf`).
- PE, FE and BI (sticky) are set on `receive_done` from the matching `rx_err` bit.
- OE, PE, FE and BI are cleared by `lsr_rd_en`. If a set and a clear occur in the same cycle, the set wins.
- RXFE = `fifoen` & (PE | FE | BI).
- Timeout counter (3 bits, saturating at `TIMEOUT_CHARS`):
  - Cleared on `receive_done`, `rbr_rd_en`, `rx_fifo_empty` or ~`fifoen`.
  - Otherwise increments on `char_tick`.
  - `cti` = (count == `TIMEOUT_CHARS`) & ~`rx_fifo_empty`.
- THRE pending flag:
  - Set on a 0->1 edge of THRE, or on a 0->1 edge of `ier[1]` while THRE = 1.
  - Cleared by `thr_wr_en`, or by `iir_rd_en` while `iir` = 4'b0010.
- Interrupt priority, highest first:
  1. LS: `ier[2]` & (OE|PE|FE|BI), `iir` = 4'b0110.
  2. RDA: `ier[0]` & (`fifoen` ? ~`below_level` : `dr`), `iir` = 4'b0100.
  3. CTI: `ier[0]` & `cti`, `iir` = 4'b1100.
  4. THRE: `ier[1]` & pending, `iir` = 4'b0010.
  5. No source active: `iir` = 4'b0001.

## Timing
- Reset values: `tsr_load` = 0, `dr` = 0, `lsr` = 8'h60, `iir` = 4'b0001, `intr` = 0, FSM = IDLE, `thr_full` = 0, counter = 0, THRE pending = 0.
- Reset is synchronous. `presetn` low mid-frame returns the FSM to IDLE on the next edge and drops `tsr_load` at once.
- `lsr`, `iir`, `intr` and `tsr_load` are registered. Each reflects its inputs with 1 cycle of latency.
- `dr` is combinational.
- `tsr_load` rises 2 cycles after `thr_wr_en` from IDLE: one cycle for `thr_full`/`tx_fifo_empty` to update, one for IDLE->LOAD.
- Back-to-back characters: `tsr_load` occurs 1 cycle after `tsr_done` when `tx_avail` = 1.
- `tsr_done` arriving outside SHIFT is ignored.
- A `receive_done` coinciding with `lsr_rd_en` leaves the new error bits set.
- Toggling `fifoen` clears neither sticky flags nor the FSM.

## Test plan
- Non-FIFO TX: write THR at cycle 0 -> `tsr_load` is high at cycle 2 only. LSR THRE = 1 at cycle 4. TEMT = 0 until 1 cycle after `tsr_done`.
- FIFO TX with 3 queued bytes -> exactly 3 `tsr_load` pulses, each 1 cycle after the previous `tsr_done`. FSM ends in IDLE and `lsr` = 8'h60.
- Receive two characters without reading (non-FIFO) -> OE set. `lsr_rd_en` -> OE cleared next cycle. `receive_done` with `rx_err` = 3'b010 concurrent with `lsr_rd_en` -> FE stays 1.
- FIFO mode with `ier` = 3'b001, 1 byte held, `below_level` = 1, 4 `char_tick` pulses -> `iir` = 4'b1100 and `intr` = 1. `rbr_rd_en` -> `iir` = 4'b0001.
- LS and THRE pending together with `ier` = 3'b111 -> `iir` = 4'b0110. After `lsr_rd_en`, `iir` = 4'b0010. After `iir_rd_en`, `iir` = 4'b0001.
- Reset asserted during SHIFT -> next cycle `tsr_load` = 0, `lsr` = 8'h60, `iir` = 4'b0001. A late `tsr_done` produces no `tsr_load`.
